i2c_slave_mem: RTL

- Synthesizable I2C target (slave) with a small byte-addressable register memory.
- Sits on the far side of the SCL/SDA pads from apb4_i2c. It consumes the bus the master produces and answers it, so it is the downstream device model for that master.
- Protocol follows the AT24C-style random/sequential read and page write. Being RTL, the bench can run it in gate-level and FPGA bring-up as well as in simulation.

---
 rtl/i2c_slave_mem.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_mem.sv
// I2C target with a small byte-addressable memory, AT24C-style protocol.
// Sits behind the SCL/SDA pads and only ever pulls SDA low; it never stretches SCL.
module i2c_slave_mem #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         PTR_W    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_o,
    output logic             scl_dir_o,
    output logic             sda_o,
    output logic             sda_dir_o,
    output logic             busy_o,
    output logic             wr_vld_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WPTR,
        WPTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        WAIT
    } state_t;

    state_t           state;
    logic             scl_s1, scl_s2, scl_d;
    logic             sda_s1, sda_s2, sda_d;
    logic             scl_rise, scl_fall, start_cond, stop_cond;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic             rw;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [7:0]       mem [DEPTH];

    assign scl_o     = 1'b0;
    assign scl_dir_o = 1'b0;
    assign sda_o     = 1'b0;

    // Two synchronizer flops plus one history flop per line; preset high like an idle bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign ptr_next   = ptr + PTR_W'(1);

    // bit_cnt counts received bits; in RDATA it counts bits already driven,
    // with the value 8 meaning "first bit of the next byte still to be driven".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_dir_o <= 1'b0;
            busy_o    <= 1'b0;
            wr_vld_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_vld_o <= 1'b0;
            if (start_cond) begin
                state     <= ADDR;
                busy_o    <= 1'b1;
                bit_cnt   <= '0;
                sda_dir_o <= 1'b0;
            end else if (stop_cond) begin
                state     <= IDLE;
                busy_o    <= 1'b0;
                bit_cnt   <= '0;
                sda_dir_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shift[7:1] == SLV_ADDR) begin
                                rw        <= shift[0];
                                sda_dir_o <= 1'b1;
                                state     <= ADDR_ACK;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rw) begin
                                shift     <= mem[ptr];
                                sda_dir_o <= ~mem[ptr][7];
                                state     <= RDATA;
                            end else begin
                                sda_dir_o <= 1'b0;
                                state     <= WPTR;
                            end
                        end
                    end
                    WPTR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr       <= shift[PTR_W-1:0];
                            bit_cnt   <= '0;
                            sda_dir_o <= 1'b1;
                            state     <= WPTR_ACK;
                        end
                    end
                    WPTR_ACK: begin
                        if (scl_fall) begin
                            sda_dir_o <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= WDATA;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            mem[ptr]  <= shift;
                            wr_vld_o  <= 1'b1;
                            wr_addr_o <= ptr;
                            wr_data_o <= shift;
                            ptr       <= ptr_next;
                            bit_cnt   <= '0;
                            sda_dir_o <= 1'b1;
                            state     <= WDATA_ACK;
                        end
                    end
                    WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_dir_o <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_dir_o <= ~shift[7];
                                bit_cnt   <= '0;
                            end else if (bit_cnt == 4'd7) begin
                                sda_dir_o <= 1'b0;
                                state     <= RACK;
                            end else begin
                                shift     <= {shift[6:0], 1'b0};
                                sda_dir_o <= ~shift[6];
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            ptr <= ptr_next;
                            if (!sda_s2) begin
                                shift   <= mem[ptr_next];
                                bit_cnt <= 4'd8;
                                state   <= RDATA;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                    end
                    default: begin
                        state     <= IDLE;
                        sda_dir_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
